// File: rtl/ltl_monitor_sched_if.sv
// Requester and automaton-side signals of the LTL monitor scheduler.
// master = requesters/automaton side, slave = the scheduler.
interface ltl_monitor_sched_if #(
  parameter int NUM_REQ    = 2,
  parameter int NUM_REPORT = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*8-1:0]  req_symbol;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  aut_reset;
  logic                  aut_run;
  logic [7:0]            aut_symbols;
  logic [NUM_REPORT-1:0] aut_report;

  modport master (
    output req_valid, req_symbol, aut_report,
    input  req_ready, aut_reset, aut_run, aut_symbols
  );

  modport slave (
    input  req_valid, req_symbol, aut_report,
    output req_ready, aut_reset, aut_run, aut_symbols
  );
endinterface

// File: rtl/ltl_monitor_sched.sv
// Sequencing controller for one LTL automaton: round-robin symbol arbitration, init/halt control.
// Optional LTL_MONITOR_SCHED_TIMESTAMP_EN adds report_index/report_src capture ports.
module ltl_monitor_sched #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_REPORT  = 4,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear,
  ltl_monitor_sched_if.slave    bus,
  output logic                  violation,
  output logic [NUM_REPORT-1:0] report_latched,
  output logic                  busy,
  output logic [CNT_W-1:0]      sym_count
`ifdef LTL_MONITOR_SCHED_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0]      report_index,
  output logic [2:0]            report_src
`endif
);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_STREAM, S_HALT} state_e;

  state_e                state_q, state_d;
  logic [INIT_W-1:0]     init_cnt_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [CNT_W-1:0]      sym_count_q;
  logic                  violation_q;
  logic [NUM_REPORT-1:0] report_latched_q;
  logic                  aut_run_q;
  logic [7:0]            aut_sym_q;

  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  transfer;
  logic                  report_any;
  logic                  report_hit;
  logic                  init_entry;
  logic [7:0]            syms [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sym
    assign syms[gi] = bus.req_symbol[8*gi +: 8];
  end

  assign report_any = |bus.aut_report;
  assign report_hit = (state_q == S_STREAM) && report_any;
  assign init_entry = (state_d == S_INIT) && (state_q != S_INIT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; clear outranks a coincident report
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_INIT;
      S_INIT:   if (init_cnt_q == '0) state_d = S_STREAM;
      S_STREAM: begin
        if (clear)           state_d = S_INIT;
        else if (report_any) state_d = S_HALT;
      end
      S_HALT:   if (clear) state_d = S_INIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; a pending report suppresses any grant in the same cycle
  always_comb begin
    int                cand;
    logic [PTR_W-1:0]  cand_idx;
    grant    = '0;
    gnt_idx  = '0;
    transfer = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if ((state_q == S_STREAM) && !report_any) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand     = (int'(ptr_q) + i) % NUM_REQ;
        cand_idx = PTR_W'(cand);
        if (!transfer && bus.req_valid[cand_idx]) begin
          transfer        = 1'b1;
          gnt_idx         = cand_idx;
          grant[cand_idx] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready   = grant;
  assign bus.aut_reset   = (state_q == S_IDLE) || (state_q == S_INIT);
  assign busy            = (state_q == S_INIT) || (state_q == S_STREAM);
  assign bus.aut_run     = aut_run_q;
  assign bus.aut_symbols = aut_sym_q;
  assign violation       = violation_q;
  assign report_latched  = report_latched_q;
  assign sym_count       = sym_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_q       <= '0;
      ptr_q            <= '0;
      sym_count_q      <= '0;
      violation_q      <= 1'b0;
      report_latched_q <= '0;
      aut_run_q        <= 1'b0;
      aut_sym_q        <= '0;
    end else begin
      aut_run_q <= transfer;
      if (transfer) aut_sym_q <= syms[gnt_idx];
      if (init_entry) begin
        init_cnt_q       <= INIT_W'(INIT_CYCLES - 1);
        ptr_q            <= '0;
        sym_count_q      <= '0;
        violation_q      <= 1'b0;
        report_latched_q <= '0;
      end else begin
        if ((state_q == S_INIT) && (init_cnt_q != '0)) init_cnt_q <= init_cnt_q - INIT_W'(1);
        if (transfer) begin
          ptr_q <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
          if (sym_count_q != '1) sym_count_q <= sym_count_q + CNT_W'(1);
        end
        if (report_hit && !clear) begin
          violation_q      <= 1'b1;
          report_latched_q <= bus.aut_report;
        end
      end
    end
  end

`ifdef LTL_MONITOR_SCHED_TIMESTAMP_EN
  logic [CNT_W-1:0] report_index_q;
  logic [2:0]       report_src_q;
  logic [2:0]       last_src_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      report_index_q <= '0;
      report_src_q   <= '0;
      last_src_q     <= '0;
    end else if (init_entry) begin
      report_index_q <= '0;
      report_src_q   <= '0;
      last_src_q     <= '0;
    end else begin
      if (transfer) last_src_q <= 3'(gnt_idx);
      if (report_hit && !clear) begin
        report_index_q <= sym_count_q;
        report_src_q   <= last_src_q;
      end
    end
  end

  assign report_index = report_index_q;
  assign report_src   = report_src_q;
`endif
endmodule

// File: tb/tb_ltl_monitor_sched.sv
// Self-checking bench for ltl_monitor_sched: vector table plus hand-written corner sequences.
module tb_ltl_monitor_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic       violation;
  logic [3:0] report_latched;
  logic       busy;
  logic [3:0] sym_count;
`ifdef LTL_MONITOR_SCHED_TIMESTAMP_EN
  logic [3:0] report_index;
  logic [2:0] report_src;
`endif

  int errors = 0;
  int checks = 0;

  ltl_monitor_sched_if #(.NUM_REQ(2), .NUM_REPORT(4)) bus ();

  ltl_monitor_sched #(
    .NUM_REQ(2), .NUM_REPORT(4), .INIT_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear(clear),
    .bus(bus.slave),
    .violation(violation),
    .report_latched(report_latched),
    .busy(busy),
    .sym_count(sym_count)
`ifdef LTL_MONITOR_SCHED_TIMESTAMP_EN
    ,
    .report_index(report_index),
    .report_src(report_src)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] valid;
    logic [7:0] sym0;
    logic [7:0] sym1;
    logic [3:0] report;
    logic [1:0] exp_ready;
    logic [3:0] exp_cnt;
    logic       exp_viol;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] sb [$];
  logic [7:0] last_sym = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] exp_sym;
    bus.req_valid  = v.valid;
    bus.req_symbol = {v.sym1, v.sym0};
    bus.aut_report = v.report;
    #4;
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
    if (v.exp_ready[0])      sb.push_back(v.sym0);
    else if (v.exp_ready[1]) sb.push_back(v.sym1);
    tick();
    if (sb.size() > 0) begin
      exp_sym = sb.pop_front();
      check({tag, " aut_run"}, 32'(bus.aut_run), 32'd1);
      check({tag, " aut_symbols"}, 32'(bus.aut_symbols), 32'(exp_sym));
      last_sym = exp_sym;
    end else begin
      check({tag, " aut_run idle"}, 32'(bus.aut_run), 32'd0);
      check({tag, " aut_symbols hold"}, 32'(bus.aut_symbols), 32'(last_sym));
    end
    check({tag, " sym_count"}, 32'(sym_count), 32'(v.exp_cnt));
    check({tag, " violation"}, 32'(violation), 32'(v.exp_viol));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " aut_reset"}, 32'(bus.aut_reset), 32'd1);
    check({tag, " aut_run"}, 32'(bus.aut_run), 32'd0);
    check({tag, " aut_symbols"}, 32'(bus.aut_symbols), 32'd0);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, " violation"}, 32'(violation), 32'd0);
    check({tag, " report_latched"}, 32'(report_latched), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " sym_count"}, 32'(sym_count), 32'd0);
  endtask

  initial begin
    vec_t v;
    // Round-robin with both requesters valid, then sparse, idle, report and halt.
    for (int i = 0; i < 6; i++)
      vecs[i] = '{2'b11, 8'h10, 8'h50, 4'h0, (i % 2 == 0) ? 2'b01 : 2'b10, 4'(i + 1), 1'b0};
    vecs[6]  = '{2'b10, 8'h00, 8'hC3, 4'h0, 2'b10, 4'd7, 1'b0};
    vecs[7]  = '{2'b00, 8'h00, 8'h00, 4'h0, 2'b00, 4'd7, 1'b0};
    vecs[8]  = '{2'b01, 8'h22, 8'h00, 4'h0, 2'b01, 4'd8, 1'b0};
    vecs[9]  = '{2'b11, 8'h22, 8'h33, 4'h0, 2'b10, 4'd9, 1'b0};
    vecs[10] = '{2'b11, 8'h44, 8'h55, 4'h4, 2'b00, 4'd9, 1'b1};
    vecs[11] = '{2'b11, 8'h44, 8'h55, 4'h0, 2'b00, 4'd9, 1'b1};
    vecs[12] = '{2'b11, 8'h66, 8'h77, 4'h0, 2'b00, 4'd9, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    bus.req_valid  = '0;
    bus.req_symbol = '0;
    bus.aut_report = '0;
    repeat (2) tick();
    reset = 1'b0;
    check_reset_vals("reset");

    // clear while idle must not leave IDLE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("idle clear busy", 32'(busy), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("init1 aut_reset", 32'(bus.aut_reset), 32'd1);
    check("init1 busy", 32'(busy), 32'd1);
    check("init1 sym_count", 32'(sym_count), 32'd0);
    tick();
    check("init2 aut_reset", 32'(bus.aut_reset), 32'd1);
    tick();
    check("stream aut_reset", 32'(bus.aut_reset), 32'd0);
    check("stream busy", 32'(busy), 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("halt report_latched", 32'(report_latched), 32'h4);
    check("halt busy", 32'(busy), 32'd0);
    check("halt aut_reset", 32'(bus.aut_reset), 32'd0);

    // clear out of HALT re-initialises and streaming resumes
    bus.req_valid = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr aut_reset", 32'(bus.aut_reset), 32'd1);
    check("clr violation", 32'(violation), 32'd0);
    check("clr report_latched", 32'(report_latched), 32'd0);
    check("clr sym_count", 32'(sym_count), 32'd0);
    check("clr busy", 32'(busy), 32'd1);
    tick();
    check("clr init2 aut_reset", 32'(bus.aut_reset), 32'd1);
    tick();
    check("clr stream aut_reset", 32'(bus.aut_reset), 32'd0);
    v = '{2'b01, 8'h5A, 8'h00, 4'h0, 2'b01, 4'd1, 1'b0};
    run_vec(v, "resume");

    // clear coincident with a report: clear wins
    bus.req_valid  = '0;
    bus.aut_report = 4'b0001;
    clear = 1'b1;
    #4;
    check("clr+rep req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    clear = 1'b0;
    bus.aut_report = '0;
    check("clr+rep violation", 32'(violation), 32'd0);
    check("clr+rep report_latched", 32'(report_latched), 32'd0);
    check("clr+rep aut_reset", 32'(bus.aut_reset), 32'd1);
    repeat (2) tick();
    check("clr+rep stream aut_reset", 32'(bus.aut_reset), 32'd0);

    // counter saturates at 15 with a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      v = '{2'b01, 8'(i + 8'h80), 8'h00, 4'h0, 2'b01, (i + 1 > 15) ? 4'd15 : 4'(i + 1), 1'b0};
      run_vec(v, $sformatf("sat%0d", i));
    end

    // reset mid-stream drops the in-flight transfer
    bus.req_valid  = 2'b11;
    bus.req_symbol = {8'hBB, 8'hAA};
    reset = 1'b1;
    tick();
    check_reset_vals("midreset");
    reset = 1'b0;
    bus.req_valid = '0;
    last_sym = 8'h00;
    tick();
    check("post reset aut_symbols", 32'(bus.aut_symbols), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
